// File: rtl/zbus_arbiter.sv
// Round-robin arbiter lending the Z80 memory bus to two FPGA masters via BUSRQ/BUSAK.
// All outputs registered; the bus is handed back to the Z80 between grants, with no pre-emption.
module zbus_arbiter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int TURN    = 2
) (
  input  logic       clk_fpga,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       bus_own,
  output logic       z80_busrq_n,
  input  logic       z80_busak_n,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    REL,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       ak_sync;
  logic             ak;
  logic             win, win_nxt;
  logic             last, last_nxt;
  logic             pick;
  logic [1:0]       gnt_nxt;
  logic             busrq_n_nxt;
  logic             timeout_err_nxt;

  // BUSAK is asynchronous to clk_fpga; the synchronizer idles at "released".
  assign ak = ~ak_sync[1];

  // On a tie the master that did not win last time goes next.
  always_comb begin
    pick = ~last;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    win_nxt         = win;
    last_nxt        = last;
    gnt_nxt         = gnt;
    busrq_n_nxt     = z80_busrq_n;
    timeout_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          win_nxt     = pick;
          last_nxt    = pick;
          busrq_n_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = REQ;
        end
      end

      REQ: begin
        // A withdrawn request beats an acknowledge arriving in the same cycle.
        if (!req[win]) begin
          busrq_n_nxt = 1'b1;
          state_nxt   = WAIT_REL;
        end else if (ak) begin
          gnt_nxt   = win ? 2'b10 : 2'b01;
          state_nxt = GRANT;
        end else if (cnt == TO_LAST) begin
          busrq_n_nxt     = 1'b1;
          timeout_err_nxt = 1'b1;
          state_nxt       = WAIT_REL;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      GRANT: begin
        if (!req[win]) begin
          gnt_nxt   = 2'b00;
          cnt_nxt   = '0;
          state_nxt = REL;
        end
      end

      REL: begin
        // Keep BUSRQ asserted while the FPGA drivers turn off.
        if (cnt == TURN_LAST) begin
          busrq_n_nxt = 1'b1;
          state_nxt   = WAIT_REL;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      WAIT_REL: begin
        if (!ak) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        gnt_nxt     = 2'b00;
        busrq_n_nxt = 1'b1;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ak_sync     <= 2'b11;
      win         <= 1'b0;
      last        <= 1'b1;
      gnt         <= 2'b00;
      bus_own     <= 1'b0;
      z80_busrq_n <= 1'b1;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ak_sync     <= {ak_sync[0], z80_busak_n};
      win         <= win_nxt;
      last        <= last_nxt;
      gnt         <= gnt_nxt;
      bus_own     <= |gnt_nxt;
      z80_busrq_n <= busrq_n_nxt;
      busy        <= (state_nxt != IDLE);
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_zbus_arbiter.sv
// Bench for zbus_arbiter: Z80 model acks BUSRQ after 3 cycles; expected grants are queued and
// matched by a grant monitor, while timing points are checked directly.
module tb_zbus_arbiter;

  logic       clk_fpga = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] req      = 2'b00;
  logic [1:0] gnt;
  logic       bus_own;
  logic       z80_busrq_n;
  logic       z80_busak_n;
  logic       busy;
  logic       timeout_err;

  int         nvec = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         to_pulses = 0;
  bit         ack_en = 1'b1;
  bit         seen_release = 1'b1;
  logic [1:0] prev_gnt = 2'b00;
  logic [2:0] apipe = 3'b111;
  logic [1:0] gnt_q[$];

  zbus_arbiter #(.CNT_W(8), .TIMEOUT(8), .TURN(2)) dut (
    .clk_fpga    (clk_fpga),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .bus_own     (bus_own),
    .z80_busrq_n (z80_busrq_n),
    .z80_busak_n (z80_busak_n),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_fpga = ~clk_fpga;

  // Z80 model: BUSAK follows BUSRQ three cycles later, or never when ack_en is cleared.
  always @(posedge clk_fpga) apipe <= {apipe[1:0], z80_busrq_n};
  assign z80_busak_n = ack_en ? apipe[2] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    cyc++;
    #1;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt == 2'b00 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, gnt != 2'b00}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Grant monitor: each new grant must be the next queued expectation, after a BUSRQ release.
  always @(negedge clk_fpga) begin
    if (timeout_err === 1'b1) to_pulses++;
    if (z80_busrq_n === 1'b1) seen_release = 1'b1;
    if (rst_n && gnt != 2'b00 && gnt != prev_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", gnt, 2'b00);
      end else begin
        chk("gnt_order", gnt, gnt_q.pop_front());
      end
      chk("busrq_released_between", {31'd0, seen_release}, 32'd1);
      seen_release = 1'b0;
    end
    prev_gnt = gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int idx;

    // Reset values
    tick();
    tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_bus_own", bus_own, 1'b0);
    chk("rst_busrq_n", z80_busrq_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;

    // Single request from master 0
    while (cyc < 10) tick();
    req = 2'b01;
    gnt_q.push_back(2'b01);
    chk("single_busrq_c10", z80_busrq_n, 1'b1);
    tick();
    chk("single_busrq_c11", z80_busrq_n, 1'b0);
    chk("single_busy_c11", busy, 1'b1);
    while (cyc < 16) tick();
    chk("single_gnt_c16", gnt, 2'b00);
    tick();
    chk("single_gnt_c17", gnt, 2'b01);
    chk("single_bus_own_c17", bus_own, 1'b1);
    while (cyc < 30) tick();
    req = 2'b00;
    tick();
    chk("single_gnt_c31", gnt, 2'b00);
    chk("single_bus_own_c31", bus_own, 1'b0);
    chk("single_busrq_c31", z80_busrq_n, 1'b0);
    tick();
    chk("single_busrq_c32", z80_busrq_n, 1'b0);
    tick();
    chk("single_busrq_c33", z80_busrq_n, 1'b1);
    while (cyc < 38) tick();
    chk("single_busy_c38", busy, 1'b1);
    tick();
    chk("single_busy_c39", busy, 1'b0);

    // Tie: both masters request continuously, grants must alternate from master 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11;
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01);
    for (int i = 0; i < 3; i++) begin
      wait_gnt("tie_wait_gnt");
      idx = (gnt == 2'b10) ? 1 : 0;
      repeat (10) tick();
      if (i < 2) begin
        req[idx] = 1'b0;
        tick();
        req[idx] = 1'b1;
      end else begin
        req = 2'b00;
      end
    end
    wait_idle("tie_idle");
    chk("tie_queue_drained", gnt_q.size(), 0);

    // BUSAK timeout
    repeat (5) tick();
    ack_en = 1'b0;
    to_pulses = 0;
    req = 2'b10;
    tick();
    begin
      int low = 0;
      while (z80_busrq_n == 1'b0 && low < 40) begin
        low++;
        tick();
      end
      req = 2'b00;
      chk("to_busrq_low_len", low, 8);
    end
    chk("to_err_pulse", timeout_err, 1'b1);
    chk("to_gnt", gnt, 2'b00);
    tick();
    chk("to_err_one_cycle", timeout_err, 1'b0);
    tick();
    chk("to_busy_after", busy, 1'b0);
    chk("to_pulse_count", to_pulses, 1);
    ack_en = 1'b1;

    // Abort while waiting for BUSAK
    repeat (5) tick();
    to_pulses = 0;
    req = 2'b01;
    tick();
    chk("abort_busrq_low", z80_busrq_n, 1'b0);
    tick();
    tick();
    req = 2'b00;
    tick();
    chk("abort_busrq_high", z80_busrq_n, 1'b1);
    chk("abort_gnt", gnt, 2'b00);
    wait_idle("abort_idle");
    chk("abort_no_timeout", to_pulses, 0);
    chk("abort_queue_empty", gnt_q.size(), 0);

    // Reset while master 1 holds the bus
    repeat (5) tick();
    req = 2'b10;
    gnt_q.push_back(2'b10);
    wait_gnt("rstmid_wait_gnt");
    repeat (3) tick();
    chk("rstmid_gnt_before", gnt, 2'b10);
    rst_n = 1'b0;
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    chk("rstmid_gnt", gnt, 2'b00);
    chk("rstmid_bus_own", bus_own, 1'b0);
    chk("rstmid_busrq_n", z80_busrq_n, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    repeat (8) tick();
    req = 2'b11;
    gnt_q.push_back(2'b01);
    wait_gnt("rstmid_tie_gnt");
    chk("rstmid_tie_winner", gnt, 2'b01);
    req = 2'b00;
    wait_idle("rstmid_idle");
    repeat (3) tick();
    chk("final_queue_empty", gnt_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
